// File: rtl/ini_pyld_send_proc_pkg.sv
// Shared widths, state encoding and head field offsets for the P2P initiator payload path.
package ini_pyld_send_proc_pkg;

  localparam int unsigned P2P_DATA_W     = 256;
  localparam int unsigned P2P_HEAD_W     = 128;
  localparam int unsigned MSG_BLEN_WIDTH = 13;
  localparam int unsigned QUEUE_NUM_LOG  = 4;
  localparam int unsigned QUEUE_NUM      = 1 << QUEUE_NUM_LOG;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BPB            = P2P_DATA_W / 8;
  localparam int unsigned BPB_LOG        = 5;
  localparam int unsigned BEAT_CNT_W     = MSG_BLEN_WIDTH - 4;

  localparam int unsigned IS_WR_BIT = 127;
  localparam int unsigned ADDR_LSB  = 32;
  localparam int unsigned BLEN_LSB  = 0;

  typedef enum logic [3:0] {
    ST_INIT = 4'b0001,
    ST_IDLE = 4'b0010,
    ST_SEND = 4'b0100,
    ST_DROP = 4'b1000
  } state_e;

  // Number of payload beats needed to carry blen bytes (ceil(blen / BPB)).
  function automatic logic [BEAT_CNT_W-1:0] calc_exp_beats(input logic [MSG_BLEN_WIDTH-1:0] blen);
    logic [MSG_BLEN_WIDTH:0] sum;
    sum = {1'b0, blen} + (MSG_BLEN_WIDTH + 1)'(BPB - 1);
    return BEAT_CNT_W'(sum >> BPB_LOG);
  endfunction

endpackage

// File: rtl/ini_pyld_send_proc_head_pack.sv
// Packs {is_wr, addr, blen} into a p2p_req head; reserved fields are zero.
module p2p_head_pack
  import ini_pyld_send_proc_pkg::*;
(
  input  logic                      is_wr_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [MSG_BLEN_WIDTH-1:0] blen_i,
  output logic [P2P_HEAD_W-1:0]     head_o
);

  // Place each field at its fixed offset, everything else reserved zero
  always_comb begin
    head_o                              = '0;
    head_o[IS_WR_BIT]                   = is_wr_i;
    head_o[ADDR_LSB +: ADDR_W]          = addr_i;
    head_o[BLEN_LSB +: MSG_BLEN_WIDTH]  = blen_i;
  end

endmodule

// File: rtl/ini_pyld_send_proc.sv
// Initiator payload transmit processor: per-queue send/drop, head build, beat forwarding.
module ini_pyld_send_proc
  import ini_pyld_send_proc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  output logic                      init_end,
  input  logic                      desc_valid,
  input  logic [QUEUE_NUM_LOG-1:0]  desc_qnum,
  input  logic [ADDR_W-1:0]         desc_addr,
  input  logic [MSG_BLEN_WIDTH-1:0] desc_blen,
  output logic                      desc_ready,
  input  logic                      pyld_valid,
  input  logic                      pyld_last,
  input  logic [P2P_DATA_W-1:0]     pyld_data,
  output logic                      pyld_ready,
  output logic                      p2p_req_valid,
  output logic                      p2p_req_last,
  output logic [P2P_HEAD_W-1:0]     p2p_req_head,
  output logic [P2P_DATA_W-1:0]     p2p_req_data,
  input  logic                      p2p_req_ready,
  input  logic                      qen_wen,
  input  logic [QUEUE_NUM_LOG-1:0]  qen_qnum,
  input  logic                      qen_data,
  output logic                      len_err
);

  state_e                    state_q, state_d;
  logic [QUEUE_NUM_LOG-1:0]  tab_index_q;
  logic                      init_end_q;
  logic [QUEUE_NUM-1:0]      en_tab_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [MSG_BLEN_WIDTH-1:0] blen_q;
  logic [BEAT_CNT_W-1:0]     exp_beats_q;
  logic [BEAT_CNT_W-1:0]     beat_cnt_q;
  logic                      len_err_q, len_err_d;
  logic [P2P_HEAD_W-1:0]     head_w;
  logic                      desc_hs;
  logic                      beat_acc;

  assign desc_hs  = desc_valid & desc_ready;
  assign beat_acc = pyld_valid & pyld_ready;
  assign init_end = init_end_q;
  assign len_err  = len_err_q;

  p2p_head_pack u_head_pack (
    .is_wr_i (1'b1),
    .addr_i  (addr_q),
    .blen_i  (blen_q),
    .head_o  (head_w)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next-state and length-error decode
  always_comb begin
    state_d   = state_q;
    len_err_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (tab_index_q == QUEUE_NUM_LOG'(QUEUE_NUM - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (desc_hs) begin
          if (desc_blen == '0)          len_err_d = 1'b1;
          else if (en_tab_q[desc_qnum]) state_d   = ST_SEND;
          else                          state_d   = ST_DROP;
        end
      end
      ST_SEND, ST_DROP: begin
        if (beat_acc && pyld_last) begin
          state_d   = ST_IDLE;
          len_err_d = ((beat_cnt_q + BEAT_CNT_W'(1)) != exp_beats_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and forwarding outputs; the SEND path is a zero-latency pass-through
  always_comb begin
    desc_ready    = 1'b0;
    pyld_ready    = 1'b0;
    p2p_req_valid = 1'b0;
    p2p_req_last  = 1'b0;
    p2p_req_head  = '0;
    p2p_req_data  = '0;
    case (state_q)
      ST_IDLE: desc_ready = 1'b1;
      ST_SEND: begin
        pyld_ready    = p2p_req_ready;
        p2p_req_valid = pyld_valid;
        p2p_req_last  = pyld_last;
        p2p_req_head  = head_w;
        p2p_req_data  = pyld_data;
      end
      ST_DROP: pyld_ready = 1'b1;
      default: ;
    endcase
  end

  // Post-reset sweep index and completion flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tab_index_q <= '0;
      init_end_q  <= 1'b0;
    end else if (state_q == ST_INIT) begin
      tab_index_q <= tab_index_q + QUEUE_NUM_LOG'(1);
      if (tab_index_q == QUEUE_NUM_LOG'(QUEUE_NUM - 1)) init_end_q <= 1'b1;
    end
  end

  // Queue enable table: cleared by the sweep, then written by software
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_tab_q <= '0;
    end else if (state_q == ST_INIT) begin
      en_tab_q[tab_index_q] <= 1'b0;
    end else if (init_end_q && qen_wen) begin
      en_tab_q[qen_qnum] <= qen_data;
    end
  end

  // Descriptor latch, beat counter and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      blen_q      <= '0;
      exp_beats_q <= '0;
      beat_cnt_q  <= '0;
      len_err_q   <= 1'b0;
    end else begin
      len_err_q <= len_err_d;
      if (desc_hs) begin
        addr_q      <= desc_addr;
        blen_q      <= desc_blen;
        exp_beats_q <= calc_exp_beats(desc_blen);
        beat_cnt_q  <= '0;
      end else if (beat_acc) begin
        beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ini_pyld_send_proc.sv
// Self-checking bench for ini_pyld_send_proc with a queue-table/packet reference model.
module tb_ini_pyld_send_proc;

  logic         clk = 1'b0;
  logic         rst;
  logic         init_end;
  logic         desc_valid;
  logic [3:0]   desc_qnum;
  logic [31:0]  desc_addr;
  logic [12:0]  desc_blen;
  logic         desc_ready;
  logic         pyld_valid;
  logic         pyld_last;
  logic [255:0] pyld_data;
  logic         pyld_ready;
  logic         p2p_req_valid;
  logic         p2p_req_last;
  logic [127:0] p2p_req_head;
  logic [255:0] p2p_req_data;
  logic         p2p_req_ready;
  logic         qen_wen;
  logic [3:0]   qen_qnum;
  logic         qen_data;
  logic         len_err;

  int total = 0;
  int bad   = 0;
  bit [15:0] en_m;

  always #5 clk = ~clk;

  ini_pyld_send_proc dut (
    .clk           (clk),
    .rst           (rst),
    .init_end      (init_end),
    .desc_valid    (desc_valid),
    .desc_qnum     (desc_qnum),
    .desc_addr     (desc_addr),
    .desc_blen     (desc_blen),
    .desc_ready    (desc_ready),
    .pyld_valid    (pyld_valid),
    .pyld_last     (pyld_last),
    .pyld_data     (pyld_data),
    .pyld_ready    (pyld_ready),
    .p2p_req_valid (p2p_req_valid),
    .p2p_req_last  (p2p_req_last),
    .p2p_req_head  (p2p_req_head),
    .p2p_req_data  (p2p_req_data),
    .p2p_req_ready (p2p_req_ready),
    .qen_wen       (qen_wen),
    .qen_qnum      (qen_qnum),
    .qen_data      (qen_data),
    .len_err       (len_err)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Count cycles from reset release to init_end; optionally try a table write during the sweep.
  task automatic wait_init(input bit poke);
    int cyc = 0;
    bit to  = 1'b1;
    if (poke) begin
      qen_wen = 1'b1; qen_qnum = 4'd3; qen_data = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      chk("init_desc_ready", desc_ready, 1'b0);
      @(posedge clk); #1;
      qen_wen = 1'b0;
      cyc++;
      if (init_end) begin
        to = 1'b0;
        break;
      end
    end
    chk("init_timeout", to, 1'b0);
    chk("init_cycles", cyc, 16);
    chk("idle_desc_ready", desc_ready, 1'b1);
    en_m = '0;
  endtask

  task automatic qen_write(input logic [3:0] q, input logic d);
    qen_wen = 1'b1; qen_qnum = q; qen_data = d;
    @(posedge clk); #1;
    qen_wen = 1'b0;
    en_m[q] = d;
  endtask

  // One descriptor plus nbeats payload beats, checked cycle by cycle against the model.
  task automatic do_packet(input logic [3:0] q, input logic [31:0] addr, input logic [12:0] blen,
                           input int nbeats, input bit use_pat, input logic [7:0] pat, input bit mid_qen);
    bit           is_send;
    int           exp_beats;
    logic [127:0] head_e;
    int           beat = 0;
    int           cyc = 0;
    int           out_cnt = 0;
    int           bound;
    bit           qen_done = 1'b0;
    logic         v, r, acc;
    logic [255:0] d;

    is_send   = en_m[q];
    exp_beats = (int'(blen) + 31) / 32;
    head_e    = (128'(1) << 127) | (128'(addr) << 32) | 128'(blen);
    bound     = nbeats * 20 + 50;

    desc_valid = 1'b1; desc_qnum = q; desc_addr = addr; desc_blen = blen;
    #1;
    chk("desc_ready_idle", desc_ready, 1'b1);
    @(posedge clk); #1;
    desc_valid = 1'b0;

    if (blen == 13'd0) begin
      chk("zero_len_err", len_err, 1'b1);
      pyld_valid = 1'b1;
      #1;
      chk("zero_no_pyld", pyld_ready, 1'b0);
      chk("zero_desc_ready", desc_ready, 1'b1);
      pyld_valid = 1'b0;
      @(posedge clk); #1;
      chk("zero_err_pulse", len_err, 1'b0);
      return;
    end

    while (beat < nbeats && cyc < bound) begin
      v = use_pat ? 1'b1 : ($urandom_range(0, 3) != 0);
      r = use_pat ? pat[cyc % 8] : 1'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      pyld_valid    = v;
      pyld_last     = v && (beat == nbeats - 1);
      pyld_data     = d;
      p2p_req_ready = r;
      if (mid_qen && beat == 1 && !qen_done) begin
        qen_wen = 1'b1; qen_qnum = q; qen_data = 1'b0;
        en_m[q] = 1'b0;
        qen_done = 1'b1;
      end
      #1;
      if (is_send) begin
        chk("send_valid", p2p_req_valid, v);
        chk("send_pyld_ready", pyld_ready, r);
        chk("send_head", p2p_req_head, head_e);
        if (v) begin
          chk("send_data", p2p_req_data, d);
          chk("send_last", p2p_req_last, (beat == nbeats - 1));
        end
      end else begin
        chk("drop_valid", p2p_req_valid, 1'b0);
        chk("drop_pyld_ready", pyld_ready, 1'b1);
        chk("drop_head", p2p_req_head, 128'd0);
      end
      acc = v && (is_send ? r : 1'b1);
      if (p2p_req_valid && p2p_req_ready) out_cnt++;
      @(posedge clk); #1;
      qen_wen = 1'b0; pyld_valid = 1'b0; pyld_last = 1'b0;
      if (acc) beat++;
      cyc++;
    end
    chk("pkt_timeout", (cyc >= bound), 1'b0);
    chk("end_len_err", len_err, (nbeats != exp_beats));
    chk("end_idle", desc_ready, 1'b1);
    chk("out_beats", out_cnt, is_send ? nbeats : 0);
    @(posedge clk); #1;
    chk("err_pulse_once", len_err, 1'b0);
  endtask

  initial begin
    logic [3:0]  rq;
    logic [12:0] rb;
    int          eb, nb;

    rst = 1'b1;
    desc_valid = 1'b0; desc_qnum = '0; desc_addr = '0; desc_blen = '0;
    pyld_valid = 1'b0; pyld_last = 1'b0; pyld_data = '0;
    p2p_req_ready = 1'b0; qen_wen = 1'b0; qen_qnum = '0; qen_data = 1'b0;
    en_m = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_end", init_end, 1'b0);
    chk("rst_desc_ready", desc_ready, 1'b0);
    chk("rst_pyld_ready", pyld_ready, 1'b0);
    chk("rst_req_valid", p2p_req_valid, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    rst = 1'b0;

    // Enable-table sweep length
    wait_init(1'b0);

    // Enabled queue, exact length
    qen_write(4'd3, 1'b1);
    do_packet(4'd3, 32'h1000_0040, 13'd64, 2, 1'b0, 8'h00, 1'b0);

    // Disabled queue drops its payload
    do_packet(4'd5, 32'h2000_0000, 13'd96, 3, 1'b0, 8'h00, 1'b0);

    // Backpressure pattern 1,0,0,1
    do_packet(4'd3, 32'h3000_0080, 13'd64, 2, 1'b1, 8'b1111_1001, 1'b0);

    // Short packet and zero-length descriptor
    do_packet(4'd3, 32'h4000_0000, 13'd33, 1, 1'b0, 8'h00, 1'b0);
    do_packet(4'd3, 32'h4000_0100, 13'd0, 0, 1'b0, 8'h00, 1'b0);

    // Randomized packets with random table updates and length mismatches
    for (int k = 0; k < 12; k++) begin
      rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) qen_write(rq, 1'($urandom_range(0, 1)));
      rb = 13'($urandom_range(1, 400));
      eb = (int'(rb) + 31) / 32;
      nb = eb;
      case ($urandom_range(0, 3))
        0: nb = eb + 1;
        1: if (eb > 1) nb = eb - 1;
        default: ;
      endcase
      do_packet(rq, $urandom, rb, nb, 1'b0, 8'h00, 1'b0);
    end

    // Maximum byte length on an enabled queue
    qen_write(4'd9, 1'b1);
    do_packet(4'd9, 32'hFFFF_FFE0, 13'd8191, 256, 1'b1, 8'hFF, 1'b0);

    // Disable q3 while its packet is in flight; the packet still goes out, the next one drops
    qen_write(4'd3, 1'b1);
    do_packet(4'd3, 32'h5000_0000, 13'd64, 2, 1'b0, 8'h00, 1'b1);
    do_packet(4'd3, 32'h5000_0040, 13'd32, 1, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a SEND packet
    qen_write(4'd7, 1'b1);
    desc_valid = 1'b1; desc_qnum = 4'd7; desc_addr = 32'hA5A5_0000; desc_blen = 13'd96;
    @(posedge clk); #1;
    desc_valid = 1'b0;
    pyld_valid = 1'b1; pyld_last = 1'b0; pyld_data = {8{32'hDEAD_BEEF}}; p2p_req_ready = 1'b1;
    #1;
    chk("mid_valid", p2p_req_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_req_valid", p2p_req_valid, 1'b0);
    chk("mrst_req_last", p2p_req_last, 1'b0);
    chk("mrst_head", p2p_req_head, 128'd0);
    chk("mrst_data", p2p_req_data, 256'd0);
    chk("mrst_pyld_ready", pyld_ready, 1'b0);
    chk("mrst_desc_ready", desc_ready, 1'b0);
    chk("mrst_init_end", init_end, 1'b0);
    @(posedge clk); #1;
    pyld_valid = 1'b0; p2p_req_ready = 1'b0;
    rst = 1'b0;
    wait_init(1'b1);

    // q3 reads disabled after the sweep (write during the sweep ignored)
    do_packet(4'd3, 32'h6000_0000, 13'd32, 1, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
